// File: rtl/fifo_pkg.sv
// Shared helpers for the extended synchronous FIFO: width math and
// parameter legality checks evaluated at elaboration time.
package fifo_pkg;

  // Ceiling log2; clog2(1) = 0, clog2(8) = 3, clog2(9) = 4.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Pointer width: enough bits to index FIFO_DEPTH entries.
  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

  // Count width: must represent 0..FIFO_DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  // Legal configuration: depth >= 2, AF in 1..depth, AE in 0..depth-1.
  function automatic bit params_ok(input int depth, input int af, input int ae);
    return (depth >= 2) && (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int PW         = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // Write the accepted word at the write pointer.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO of arbitrary depth with fill count, programmable
// almost flags, sticky error flags and optional first-word-fall-through.
module sync_fifo_ext
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cs,
  input  logic                                wr_en,
  input  logic                                rd_en,
  input  logic [DATA_WIDTH-1:0]               data_in,
  input  logic                                clr_err,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic                                empty,
  output logic                                full,
  output logic                                almost_empty,
  output logic                                almost_full,
  output logic [clog2(FIFO_DEPTH+1)-1:0]      count,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);

  if (!params_ok(FIFO_DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_err
    $error("sync_fifo_ext: illegal FIFO_DEPTH / AF_THRESH / AE_THRESH");
  end

  logic [PW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]         count_nxt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_acc, wr_acc;
  logic                  ov_set, uf_set;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write
  // alongside a read; an empty FIFO never serves a read, even with a write.
  assign rd_acc = cs & rd_en & ~empty;
  assign wr_acc = cs & wr_en & (~full | rd_acc);
  assign ov_set = cs & wr_en & ~wr_acc;
  assign uf_set = cs & rd_en & ~rd_acc;

  // Next-state pointers and count; wrap is explicit so any depth works.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (wr_acc) wr_ptr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
    if (rd_acc) rd_ptr_nxt = (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, count and status flags, all registered from next-state count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_C);
      almost_empty <= (count_nxt <= AE_C);
      almost_full  <= (count_nxt >= AF_C);
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ov_set)       overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (uf_set)       underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PW         (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    // Head entry is always presented; zero while nothing is held.
    assign data_out = empty ? '0 : rd_data;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    // Capture the head entry on an accepted read, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         dout_q <= '0;
      else if (rd_acc) dout_q <= rd_data;
    end
    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: a standard-read instance (depth 8) and a FWFT
// instance (depth 5) share one stimulus stream and are compared against
// queue-based reference models, plus a hand-computed vector table.
module tb_sync_fifo_ext;

  logic        clk, rst, cs, wr_en, rd_en, clr_err;
  logic [31:0] data_in;

  logic [31:0] a_dout, b_dout;
  logic        a_empty, a_full, a_ae, a_af, a_ov, a_uf;
  logic        b_empty, b_full, b_ae, b_af, b_ov, b_uf;
  logic [3:0]  a_cnt;
  logic [2:0]  b_cnt;

  sync_fifo_ext #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .clr_err(clr_err), .data_out(a_dout), .empty(a_empty), .full(a_full),
    .almost_empty(a_ae), .almost_full(a_af), .count(a_cnt), .overflow(a_ov), .underflow(a_uf));

  sync_fifo_ext #(.DATA_WIDTH(32), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1)) u_b (
    .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .clr_err(clr_err), .data_out(b_dout), .empty(b_empty), .full(b_full),
    .almost_empty(b_ae), .almost_full(b_af), .count(b_cnt), .overflow(b_ov), .underflow(b_uf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference models: contents as queues, plus output register and flags.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] ma_dout, mb_dout;
  bit          ma_ov, ma_uf, mb_ov, mb_uf;

  typedef struct {
    bit          c, w, r, cl;
    logic [31:0] din;
    int          cnt;
    logic [31:0] dout;
    bit          ov, uf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit c, bit w, bit r, bit cl, logic [31:0] din,
                              int cnt, logic [31:0] dout, bit ov, bit uf);
    vec_t v;
    v.c = c; v.w = w; v.r = r; v.cl = cl; v.din = din;
    v.cnt = cnt; v.dout = dout; v.ov = ov; v.uf = uf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of FIFO semantics at the queue level.
  task automatic mstep(inout logic [31:0] q[$], input int depth, input bit fwft,
                       inout logic [31:0] dq, inout bit ov, inout bit uf,
                       input bit c, input bit w, input bit r, input bit cl,
                       input logic [31:0] d);
    bit rd_ok, wr_ok;
    logic [31:0] popped;
    rd_ok = c && r && (q.size() > 0);
    wr_ok = c && w && ((q.size() < depth) || rd_ok);
    if (rd_ok) begin
      popped = q.pop_front();
      if (!fwft) dq = popped;
    end
    if (wr_ok) q.push_back(d);
    if (c && w && !wr_ok) ov = 1'b1; else if (cl) ov = 1'b0;
    if (c && r && !rd_ok) uf = 1'b1; else if (cl) uf = 1'b0;
  endtask

  task automatic check_models(input string tag);
    chk({tag, " a_count"}, 32'(a_cnt), 32'(qa.size()));
    chk({tag, " a_empty"}, 32'(a_empty), 32'(qa.size() == 0));
    chk({tag, " a_full"},  32'(a_full),  32'(qa.size() == 8));
    chk({tag, " a_ae"},    32'(a_ae),    32'(qa.size() <= 2));
    chk({tag, " a_af"},    32'(a_af),    32'(qa.size() >= 6));
    chk({tag, " a_ov"},    32'(a_ov),    32'(ma_ov));
    chk({tag, " a_uf"},    32'(a_uf),    32'(ma_uf));
    chk({tag, " a_dout"},  a_dout,       ma_dout);
    chk({tag, " b_count"}, 32'(b_cnt), 32'(qb.size()));
    chk({tag, " b_empty"}, 32'(b_empty), 32'(qb.size() == 0));
    chk({tag, " b_full"},  32'(b_full),  32'(qb.size() == 5));
    chk({tag, " b_ae"},    32'(b_ae),    32'(qb.size() <= 1));
    chk({tag, " b_af"},    32'(b_af),    32'(qb.size() >= 4));
    chk({tag, " b_ov"},    32'(b_ov),    32'(mb_ov));
    chk({tag, " b_uf"},    32'(b_uf),    32'(mb_uf));
    chk({tag, " b_dout"},  b_dout,       (qb.size() > 0) ? qb[0] : 32'h0);
  endtask

  // Drive on the falling edge, let the rising edge act, sample 1 ns later.
  task automatic step(input string tag, input bit c, input bit w, input bit r,
                      input bit cl, input logic [31:0] d);
    @(negedge clk);
    cs = c; wr_en = w; rd_en = r; clr_err = cl; data_in = d;
    @(posedge clk);
    mstep(qa, 8, 1'b0, ma_dout, ma_ov, ma_uf, c, w, r, cl, d);
    mstep(qb, 5, 1'b1, mb_dout, mb_ov, mb_uf, c, w, r, cl, d);
    #1;
    check_models(tag);
  endtask

  // Assert reset between edges and confirm outputs drop without a clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    cs = 0; wr_en = 0; rd_en = 0; clr_err = 0; data_in = '0;
    #2 rst = 1'b1;
    #1;
    chk({tag, " a_count"}, 32'(a_cnt), 0);
    chk({tag, " a_empty"}, 32'(a_empty), 1);
    chk({tag, " a_full"},  32'(a_full), 0);
    chk({tag, " a_ae"},    32'(a_ae), 1);
    chk({tag, " a_af"},    32'(a_af), 0);
    chk({tag, " a_dout"},  a_dout, 0);
    chk({tag, " a_ov"},    32'(a_ov), 0);
    chk({tag, " a_uf"},    32'(a_uf), 0);
    chk({tag, " b_count"}, 32'(b_cnt), 0);
    chk({tag, " b_empty"}, 32'(b_empty), 1);
    chk({tag, " b_dout"},  b_dout, 0);
    qa.delete(); qb.delete();
    ma_dout = '0; mb_dout = '0;
    ma_ov = 0; ma_uf = 0; mb_ov = 0; mb_uf = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b1; cs = 0; wr_en = 0; rd_en = 0; clr_err = 0; data_in = '0;
    ma_dout = '0; mb_dout = '0;

    // Standard-read scenarios on the depth-8 instance, expectations by hand.
    vecs.push_back(mk(1,1,0,0, 32'd1,   1, 0, 0, 0));
    vecs.push_back(mk(1,1,0,0, 32'd10,  2, 0, 0, 0));
    vecs.push_back(mk(1,1,0,0, 32'd100, 3, 0, 0, 0));
    vecs.push_back(mk(1,0,1,0, 32'd0,   2, 1, 0, 0));
    vecs.push_back(mk(1,0,1,0, 32'd0,   1, 10, 0, 0));
    vecs.push_back(mk(1,0,1,0, 32'd0,   0, 100, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1,1,0,0, 32'(1) << i, i + 1, 100, 0, 0));
    vecs.push_back(mk(1,1,0,0, 32'hDEAD, 8, 100, 1, 0));
    vecs.push_back(mk(0,0,0,1, 32'h0,    8, 100, 0, 0));
    vecs.push_back(mk(1,1,1,0, 32'h200,  8, 1, 0, 0));
    for (int i = 1; i < 8; i++)
      vecs.push_back(mk(1,0,1,0, 32'h0, 8 - i, 32'(1) << i, 0, 0));
    vecs.push_back(mk(1,0,1,0, 32'h0,  0, 32'h200, 0, 0));
    vecs.push_back(mk(1,1,1,0, 32'hA5, 1, 32'h200, 0, 1));
    vecs.push_back(mk(0,0,0,1, 32'h0,  1, 32'h200, 0, 0));
    vecs.push_back(mk(1,0,1,0, 32'h0,  0, 32'hA5, 0, 0));
    vecs.push_back(mk(1,0,1,1, 32'h0,  0, 32'hA5, 0, 1));
    vecs.push_back(mk(0,1,1,0, 32'h77, 0, 32'hA5, 0, 1));
    vecs.push_back(mk(0,1,0,0, 32'h78, 0, 32'hA5, 0, 1));
    vecs.push_back(mk(0,0,0,1, 32'h0,  0, 32'hA5, 0, 0));

    #12;
    chk("rst a_count", 32'(a_cnt), 0);
    chk("rst a_empty", 32'(a_empty), 1);
    chk("rst a_full",  32'(a_full), 0);
    chk("rst a_ae",    32'(a_ae), 1);
    chk("rst a_af",    32'(a_af), 0);
    chk("rst a_dout",  a_dout, 0);
    chk("rst a_ov",    32'(a_ov), 0);
    chk("rst a_uf",    32'(a_uf), 0);
    chk("rst b_empty", 32'(b_empty), 1);
    chk("rst b_dout",  b_dout, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      step($sformatf("vec%0d", i), v.c, v.w, v.r, v.cl, v.din);
      chk($sformatf("vec%0d tbl_count", i), 32'(a_cnt), 32'(v.cnt));
      chk($sformatf("vec%0d tbl_dout", i),  a_dout, v.dout);
      chk($sformatf("vec%0d tbl_ov", i),    32'(a_ov), 32'(v.ov));
      chk($sformatf("vec%0d tbl_uf", i),    32'(a_uf), 32'(v.uf));
      chk($sformatf("vec%0d tbl_empty", i), 32'(a_empty), 32'(v.cnt == 0));
      chk($sformatf("vec%0d tbl_full", i),  32'(a_full), 32'(v.cnt == 8));
    end

    // FWFT: first word shows as soon as empty falls, then wrap with push/pop.
    do_reset("rst_fwft");
    chk("fwft pre dout", b_dout, 0);
    step("fwft wr", 1, 1, 0, 0, 32'h11);
    chk("fwft first dout", b_dout, 32'h11);
    chk("fwft first empty", 32'(b_empty), 0);
    for (int i = 0; i < 12; i++) begin
      step($sformatf("fwft pp%0d", i), 1, 1, 1, 0, 32'h20 + 32'(i));
      chk($sformatf("fwft pp%0d dout", i), b_dout, 32'h20 + 32'(i));
      chk($sformatf("fwft pp%0d count", i), 32'(b_cnt), 1);
    end

    // Random traffic with a drifting write/read bias to visit full and empty.
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 60) % 2 == 0) ? 75 : 25;
      step($sformatf("rnd%0d", i), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < (100 - wp)),
           ($urandom_range(0, 15) == 0), $urandom);
    end

    // Reset in the middle of a burst with four entries held.
    do_reset("rst_pre");
    for (int i = 0; i < 4; i++) step($sformatf("burst%0d", i), 1, 1, 0, 0, 32'h300 + 32'(i));
    chk("burst count", 32'(a_cnt), 4);
    do_reset("rst_mid");
    step("post rst rd", 1, 0, 1, 0, 32'h0);
    chk("post rst uf", 32'(a_uf), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
Parametrised single-clock FIFO, successor to the team's basic cs/wr_en/rd_en FIFO. It is generalised to any depth ≥ 2, not just powers of two. It adds a fill count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and an optional first-word-fall-through (FWFT) read mode. It sits between producer and consumer datapaths wherever the basic FIFO is used today.

Parameters:
DATA_WIDTH, 32, width of data_in/data_out
FIFO_DEPTH, 8, number of entries; any integer ≥ 2
AF_THRESH, 6, almost_full asserted when count ≥ AF_THRESH; legal range 1..FIFO_DEPTH
AE_THRESH, 2, almost_empty asserted when count ≤ AE_THRESH; legal range 0..FIFO_DEPTH-1
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cs  in  1  chip select; when 0, no push, pop or error update occurs
wr_en  in  1  write request
rd_en  in  1  read request
data_in  in  DATA_WIDTH  write data
clr_err  in  1  clears overflow/underflow; not gated by cs
data_out  out  DATA_WIDTH  read data
empty  out  1  count == 0
full  out  1  count == FIFO_DEPTH
almost_empty  out  1  count ≤ AE_THRESH
almost_full  out  1  count ≥ AF_THRESH
count  out  CW  entries held; CW = clog2(FIFO_DEPTH+1)
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, full = 0, almost_empty = 1
  - almost_full = 0, data_out = 0, overflow = underflow = 0
  - Memory contents are not reset.
- Accept conditions:
  - rd_acc = cs & rd_en & !empty
  - wr_acc = cs & wr_en & (!full | rd_acc), so push and pop are allowed together when full.
  - When empty, a read is rejected even if a write occurs in the same cycle.
- Pointers:
  - Each pointer increments by 1 on accept.
  - A pointer at FIFO_DEPTH-1 wraps to 0; no power-of-two assumption.
- Count:
  - +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
  - Count never exceeds FIFO_DEPTH and never goes below 0.
- Status timing:
  - empty, full, almost_* and count are registered, computed from the next-state count.
  - All of them update on the same edge as the pointers, with 1-cycle latency from request.
- Standard read (FWFT=0):
  - data_out <= mem[rd_ptr] on the rd_acc edge; it is valid from that edge.
  - data_out holds its value when there is no rd_acc.
- FWFT read (FWFT=1):
  - data_out = mem[rd_ptr] combinationally whenever empty = 0; it is 0 when empty.
  - rd_acc pops the entry and presents the next one.
  - The first word is visible the cycle after the write edge, when empty falls.
- Error flags:
  - overflow <= 1 on cs & wr_en & !wr_acc.
  - underflow <= 1 on cs & rd_en & !rd_acc.
  - clr_err clears both flags next edge; a set in the same cycle wins over clr_err.
  - Rejected operations change no other state.
- cs = 0: wr_en and rd_en are ignored entirely; no error flags are set.
- Reset mid-operation: contents are lost; outputs take their reset values immediately.

Decomposition:
- Shared package fifo_pkg:
  - clog2 function
  - derived widths: pointer width PW = clog2(FIFO_DEPTH), CW
  - parameter legality checks (elaboration-time error on an illegal AF_THRESH, AE_THRESH or FIFO_DEPTH)
- One sub-module, fifo_mem: DATA_WIDTH × FIFO_DEPTH storage with a synchronous write port and an asynchronous read port.
- Pointer, count, flag and output logic live in sync_fifo_ext.

Test Plan (FIFO_DEPTH=8, DATA_WIDTH=32, AF=6, AE=2, unless stated):
1. Reset, then write 1, 10, 100, then read ×3 with FWFT=0 -> data_out = 1, 10, 100 on successive read edges; count 0→3→0; empty re-asserts after the third read.
2. Write 2**i for i = 0..7 -> almost_empty drops when count = 3, almost_full rises when count = 6, full at count = 8; a 9th write sets overflow and leaves count at 8 and the contents intact.
3. FIFO full, assert wr_en and rd_en together -> both accepted, count stays 8, no overflow; reading out returns 2, 4 … 128, then the new word.
4. FIFO empty, rd_en together with wr_en = 0xA5 -> underflow = 1, count becomes 1; pulse clr_err -> underflow = 0; a rejected read in the same cycle as clr_err keeps underflow = 1.
5. FWFT=1, FIFO_DEPTH=5: write 0x11 -> data_out = 0x11 the cycle empty falls, before any rd_en. Then run 12 push/pop cycles -> pointers wrap 4→0 and data order is preserved.
6. cs = 0 with wr_en/rd_en toggling -> no state or flag change. Assert rst mid-burst with count = 4 -> all outputs return to reset values asynchronously.
